tsn_sp_scheduler: RTL and testbench

Strict-priority transmit scheduler for one egress port. It sits directly downstream of the per-port Qav credit manager in the txmac scheduling pipeline. It takes the eligible-queue bitmask and its valid, optionally masks it with the Qbv gate state, and grants the highest-priority queue as a one-hot result. It holds that grant for the whole frame on the MAC TX AXI-Stream, then releases it. Its outputs feed back as the credit manager's scheduling result and valid inputs.

---
 rtl/tsn_sched_pkg.sv | 14 +
 rtl/tsn_sp_scheduler_if.sv | 45 ++++
 rtl/tsn_pri_encoder.sv | 26 ++
 rtl/tsn_sp_scheduler.sv | 126 ++++++++++++
 tb/tb_tsn_sp_scheduler.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/tsn_sched_pkg.sv
// Shared types and defaults for the egress strict-priority scheduler.
// The defaults are also used by the per-port credit manager.
package tsn_sched_pkg;

    localparam int DEF_PORT_FIFO_PRI_NUM = 8;
    localparam int DEF_TIMEOUT_CYC       = 1024;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_SOF = 2'b01,
        WAIT_EOF = 2'b10
    } sched_state_e;

endpackage

// File: rtl/tsn_sp_scheduler_if.sv
// Credit-manager / Qbv / MAC TX signals as seen by the scheduler.
// The slave modport is the scheduler; master is the surrounding logic.
interface tsn_sp_scheduler_if
    import tsn_sched_pkg::*;
#(
    parameter int N = DEF_PORT_FIFO_PRI_NUM
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  i_queue;
    logic          i_queue_vld;
    logic          i_gate_en;
    logic [N-1:0]  i_gate_state;
    logic          i_mac_tx_axis_valid;
    logic          i_mac_tx_axis_last;
    logic [N-1:0]  o_scheduing_rst;
    logic          o_scheduing_rst_vld;
    logic [IW-1:0] o_pri_index;
    logic          o_busy;
    logic          o_no_elig;
    logic          o_timeout;

    modport slave (
        input  i_queue, i_queue_vld,
        input  i_gate_en, i_gate_state,
        input  i_mac_tx_axis_valid,
        input  i_mac_tx_axis_last,
        output o_scheduing_rst,
        output o_scheduing_rst_vld,
        output o_pri_index, o_busy,
        output o_no_elig, o_timeout
    );

    modport master (
        output i_queue, i_queue_vld,
        output i_gate_en, i_gate_state,
        output i_mac_tx_axis_valid,
        output i_mac_tx_axis_last,
        input  o_scheduing_rst,
        input  o_scheduing_rst_vld,
        input  o_pri_index, o_busy,
        input  o_no_elig, o_timeout
    );

endinterface

// File: rtl/tsn_pri_encoder.sv
// Combinational highest-set-bit picker: one-hot, binary index, any.
// Higher index wins, so the last set bit seen by the loop is kept.
module tsn_pri_encoder #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_mask,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_index,
    output logic          o_any
);

    always_comb begin
        o_onehot = '0;
        o_index  = '0;
        o_any    = |i_mask;
        for (int i = 0; i < N; i++) begin
            if (i_mask[i]) begin
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
                o_index     = IW'(i);
            end
        end
    end

endmodule

// File: rtl/tsn_sp_scheduler.sv
// Strict-priority egress scheduler: grants one queue and holds it
// for the duration of one MAC TX frame, with a start-of-frame timeout.
module tsn_sp_scheduler
    import tsn_sched_pkg::*;
#(
    parameter int PORT_FIFO_PRI_NUM = DEF_PORT_FIFO_PRI_NUM,
    parameter int TIMEOUT_CYC       = DEF_TIMEOUT_CYC
) (
    input logic           i_clk,
    input logic           i_rst,
    tsn_sp_scheduler_if.slave bus
);

    localparam int N  = PORT_FIFO_PRI_NUM;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYC);

    sched_state_e  state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          vld_q, vld_d;
    logic          busy_q, busy_d;
    logic          no_elig_q, no_elig_d;
    logic          timeout_q, timeout_d;

    logic [N-1:0]  mask;
    logic [N-1:0]  enc_oh;
    logic [IW-1:0] enc_idx;
    logic          enc_any;
    logic          beat, eof;

    assign mask = bus.i_gate_en ? (bus.i_queue & bus.i_gate_state)
                                : bus.i_queue;
    assign beat = bus.i_mac_tx_axis_valid;
    assign eof  = beat & bus.i_mac_tx_axis_last;

    tsn_pri_encoder #(
        .N  (N),
        .IW (IW)
    ) u_enc (
        .i_mask   (mask),
        .o_onehot (enc_oh),
        .o_index  (enc_idx),
        .o_any    (enc_any)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        vld_d     = 1'b0;
        no_elig_d = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.i_queue_vld && enc_any) begin
                    grant_d = enc_oh;
                    idx_d   = enc_idx;
                    vld_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT_SOF;
                end else if (bus.i_queue_vld) begin
                    no_elig_d = 1'b1;
                end
            end
            WAIT_SOF: begin
                if (eof) begin
                    state_d = IDLE;
                end else if (beat) begin
                    state_d = WAIT_EOF;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_EOF: begin
                if (eof) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Grant is held only while a frame is outstanding.
        if (state_d == IDLE) begin
            grant_d = '0;
            idx_d   = '0;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            vld_q     <= 1'b0;
            busy_q    <= 1'b0;
            no_elig_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            vld_q     <= vld_d;
            busy_q    <= busy_d;
            no_elig_q <= no_elig_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.o_scheduing_rst     = grant_q;
    assign bus.o_scheduing_rst_vld = vld_q;
    assign bus.o_pri_index         = idx_q;
    assign bus.o_busy              = busy_q;
    assign bus.o_no_elig           = no_elig_q;
    assign bus.o_timeout           = timeout_q;

endmodule

// File: tb/tb_tsn_sp_scheduler.sv
// Bench for tsn_sp_scheduler: table vectors, corner sequences and
// random traffic checked against a frame-level reference model.
module tb_tsn_sp_scheduler;

    localparam int N  = 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tsn_sp_scheduler_if #(.N(N)) bus ();

    tsn_sp_scheduler #(
        .PORT_FIFO_PRI_NUM (N),
        .TIMEOUT_CYC       (TO)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference: the granted queue (-1 = none), whether the frame
    // has started, and idle cycles spent waiting for its first beat.
    int m_q       = -1;
    bit m_started = 0;
    int m_wait    = 0;
    bit e_vld, e_noelig, e_to;

    task automatic check(string name, logic [31:0] act,
                         logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h",
                      name, act, exp);
    endtask

    task automatic model_reset();
        m_q = -1; m_started = 0; m_wait = 0;
        e_vld = 0; e_noelig = 0; e_to = 0;
    endtask

    task automatic model_step(logic [N-1:0] q, bit qv, bit ge,
                              logic [N-1:0] gs, bit v, bit l);
        logic [N-1:0] mm;
        int best;
        e_vld = 0; e_noelig = 0; e_to = 0;
        if (m_q < 0) begin
            if (qv) begin
                mm = ge ? (q & gs) : q;
                best = -1;
                for (int i = N - 1; i >= 0; i--)
                    if (mm[i] && best < 0) best = i;
                if (best >= 0) begin
                    m_q = best; m_started = 0; m_wait = 0;
                    e_vld = 1;
                end else e_noelig = 1;
            end
        end else if (!m_started) begin
            if (v && l) m_q = -1;
            else if (v) m_started = 1;
            else begin
                m_wait++;
                if (m_wait >= TO) begin
                    m_q = -1; e_to = 1;
                end
            end
        end else if (v && l) m_q = -1;
    endtask

    task automatic check_all();
        logic [N-1:0] eg;
        eg = (m_q < 0) ? '0 : N'(1) << m_q;
        check("grant", 32'(bus.o_scheduing_rst), 32'(eg));
        check("index", 32'(bus.o_pri_index),
              (m_q < 0) ? 32'd0 : 32'(m_q));
        check("vld", 32'(bus.o_scheduing_rst_vld), 32'(e_vld));
        check("busy", 32'(bus.o_busy), (m_q >= 0) ? 32'd1 : 32'd0);
        check("no_elig", 32'(bus.o_no_elig), 32'(e_noelig));
        check("timeout", 32'(bus.o_timeout), 32'(e_to));
    endtask

    task automatic tick();
        logic [N-1:0] q, gs;
        bit qv, ge, v, l;
        q = bus.i_queue; qv = bus.i_queue_vld;
        ge = bus.i_gate_en; gs = bus.i_gate_state;
        v = bus.i_mac_tx_axis_valid; l = bus.i_mac_tx_axis_last;
        @(posedge clk);
        #1;
        model_step(q, qv, ge, gs, v, l);
        check_all();
    endtask

    task automatic idle_in();
        bus.i_queue_vld = 0;
        bus.i_mac_tx_axis_valid = 0;
        bus.i_mac_tx_axis_last = 0;
    endtask

    task automatic strobe(logic [N-1:0] q, bit ge, logic [N-1:0] gs);
        bus.i_queue = q; bus.i_gate_en = ge; bus.i_gate_state = gs;
        bus.i_queue_vld = 1;
        tick();
        bus.i_queue_vld = 0;
    endtask

    task automatic beat(bit l);
        bus.i_mac_tx_axis_valid = 1;
        bus.i_mac_tx_axis_last = l;
        tick();
        idle_in();
    endtask

    typedef struct {
        logic [N-1:0] q;
        bit           ge;
        logic [N-1:0] gs;
        logic [N-1:0] eg;
        int           ei;
        bit           en;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int pct;
        vecs[0] = '{8'h2C, 0, 8'h00, 8'h20, 5, 0};
        vecs[1] = '{8'hC1, 1, 8'h3F, 8'h01, 0, 0};
        vecs[2] = '{8'h80, 1, 8'h7F, 8'h00, 0, 1};
        vecs[3] = '{8'hFF, 0, 8'h00, 8'h80, 7, 0};
        vecs[4] = '{8'h01, 0, 8'hFF, 8'h01, 0, 0};
        vecs[5] = '{8'h00, 0, 8'hFF, 8'h00, 0, 1};
        vecs[6] = '{8'hFF, 1, 8'h00, 8'h00, 0, 1};
        vecs[7] = '{8'h5A, 1, 8'h0F, 8'h08, 3, 0};

        bus.i_queue = '0; bus.i_gate_en = 0; bus.i_gate_state = '0;
        idle_in();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", 32'(bus.o_scheduing_rst), 0);
        check("rst_busy", 32'(bus.o_busy), 0);
        check("rst_vld", 32'(bus.o_scheduing_rst_vld), 0);
        rst = 0;
        tick();

        foreach (vecs[k]) begin
            strobe(vecs[k].q, vecs[k].ge, vecs[k].gs);
            check("tbl_grant", 32'(bus.o_scheduing_rst),
                  32'(vecs[k].eg));
            check("tbl_index", 32'(bus.o_pri_index), 32'(vecs[k].ei));
            check("tbl_noelig", 32'(bus.o_no_elig), 32'(vecs[k].en));
            check("tbl_busy", 32'(bus.o_busy), 32'(!vecs[k].en));
            if (!vecs[k].en) begin
                beat(1);
                check("tbl_clear", 32'(bus.o_scheduing_rst), 0);
            end
            tick();
        end

        // Four-beat frame: grant stays up through the last beat.
        strobe(8'h2C, 0, 8'h00);
        check("f4_vld", 32'(bus.o_scheduing_rst_vld), 1);
        for (int b = 0; b < 3; b++) begin
            beat(0);
            check("f4_hold", 32'(bus.o_scheduing_rst), 32'h20);
            check("f4_vld0", 32'(bus.o_scheduing_rst_vld), 0);
        end
        check("f4_on_last", 32'(bus.o_scheduing_rst), 32'h20);
        beat(1);
        check("f4_clear", 32'(bus.o_scheduing_rst), 0);
        check("f4_busy", 32'(bus.o_busy), 0);

        // Start-of-frame timeout.
        strobe(8'h04, 0, 8'h00);
        for (int c = 0; c < TO - 1; c++) tick();
        check("to_hold", 32'(bus.o_scheduing_rst), 32'h04);
        check("to_early", 32'(bus.o_timeout), 0);
        tick();
        check("to_pulse", 32'(bus.o_timeout), 1);
        check("to_clear", 32'(bus.o_scheduing_rst), 0);
        tick();
        check("to_once", 32'(bus.o_timeout), 0);
        strobe(8'h02, 0, 8'h00);
        check("to_regrant", 32'(bus.o_scheduing_rst), 32'h02);
        beat(1);

        // Single-beat frame with a coincident strobe.
        strobe(8'h10, 0, 8'h00);
        bus.i_queue = 8'h80; bus.i_queue_vld = 1;
        bus.i_mac_tx_axis_valid = 1; bus.i_mac_tx_axis_last = 1;
        tick();
        idle_in();
        check("sb_ignored", 32'(bus.o_scheduing_rst), 0);
        check("sb_vld", 32'(bus.o_scheduing_rst_vld), 0);
        strobe(8'h80, 0, 8'h00);
        check("sb_next", 32'(bus.o_scheduing_rst), 32'h80);
        beat(1);

        // Reset in the middle of a frame.
        strobe(8'h40, 0, 8'h00);
        beat(0);
        rst = 1;
        #1;
        check("mr_grant", 32'(bus.o_scheduing_rst), 0);
        check("mr_busy", 32'(bus.o_busy), 0);
        check("mr_index", 32'(bus.o_pri_index), 0);
        model_reset();
        #1;
        rst = 0;
        beat(1);
        check("mr_late_eof", 32'(bus.o_busy), 0);

        // Random traffic in segments of varying beat density.
        for (int s = 0; s < 6; s++) begin
            pct = (s == 2) ? 0 : (s * 17 + 5) % 70;
            for (int c = 0; c < 150; c++) begin
                bus.i_queue = N'($urandom);
                bus.i_gate_state = N'($urandom);
                bus.i_gate_en = $urandom_range(0, 1);
                bus.i_queue_vld = ($urandom_range(0, 3) == 0);
                bus.i_mac_tx_axis_valid =
                    ($urandom_range(0, 99) < pct);
                bus.i_mac_tx_axis_last = $urandom_range(0, 1);
                tick();
            end
        end
        idle_in();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
